// File: rtl/multi_channel_blinker.sv
// N-channel LED blinker with a four-button control panel.
// Buttons are synchronised and debounced. Each press acts on the selected channel's
// rate or mode, or advances the channel selection. Every channel blinks from its own
// half-period counter; rate r sets a half-period of CLK_FREQ_HZ >> r cycles.
module multi_channel_blinker #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned NUM_RATES    = 5,
    parameter int unsigned DEFAULT_RATE = 1,
    parameter int unsigned DEB_CYCLES   = 500_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   button,
    output logic [N_CH-1:0]              led,
    output logic [$clog2(N_CH)-1:0]      sel_ch,
    output logic [$clog2(NUM_RATES)-1:0] sel_rate,
    output logic [1:0]                   sel_mode
);

    localparam int unsigned N_BTN    = 4;
    localparam int unsigned SEL_W    = $clog2(N_CH);
    localparam int unsigned RATE_W   = $clog2(NUM_RATES);
    localparam int unsigned CNT_W    = $clog2(CLK_FREQ_HZ + 1);
    localparam int unsigned DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);
    localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(DEFAULT_RATE);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        MODE_BLINK = 2'b00,
        MODE_ON    = 2'b01,
        MODE_OFF   = 2'b10
    } mode_t;

    // Input conditioning state
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_stable;
    logic [N_BTN-1:0] r_press;
    logic [DEB_W-1:0] r_deb_cnt [N_BTN];

    // Control state
    logic [SEL_W-1:0]  r_sel_ch;
    logic [RATE_W-1:0] r_rate [N_CH];
    mode_t             r_mode [N_CH];
    logic [CNT_W-1:0]  r_cnt  [N_CH];
    logic [N_CH-1:0]   r_led;

    // Next-state values for the channels
    logic [RATE_W-1:0] w_rate_nxt [N_CH];
    mode_t             w_mode_nxt [N_CH];
    logic [CNT_W-1:0]  w_cnt_nxt  [N_CH];
    logic [CNT_W-1:0]  w_term     [N_CH];
    logic [N_CH-1:0]   w_led_nxt;
    logic [N_CH-1:0]   w_hit;

    // Prioritised single-cycle events: rate up > rate down > next channel > mode
    logic w_ev_up;
    logic w_ev_dn;
    logic w_ev_next;
    logic w_ev_mode;

    // Synchronise, debounce, and emit a one-cycle pulse when a button is accepted as pressed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_press  <= '0;
            for (int b = 0; b < N_BTN; b++) begin
                r_deb_cnt[b] <= '0;
            end
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            for (int b = 0; b < N_BTN; b++) begin
                r_press[b] <= 1'b0;
                if (r_sync2[b] != r_stable[b]) begin
                    if (r_deb_cnt[b] == DEB_LAST) begin
                        r_stable[b]  <= r_sync2[b];
                        r_deb_cnt[b] <= '0;
                        r_press[b]   <= r_sync2[b];
                    end else begin
                        r_deb_cnt[b] <= r_deb_cnt[b] + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt[b] <= '0;
                end
            end
        end
    end

    // Only the highest-priority simultaneous press takes effect; the rest are dropped
    always_comb begin
        w_ev_up   = r_press[0];
        w_ev_dn   = r_press[1] & ~r_press[0];
        w_ev_next = r_press[2] & ~(|r_press[1:0]);
        w_ev_mode = r_press[3] & ~(|r_press[2:0]);
    end

    // Channel selection, wrapping after the last channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_ch <= '0;
        end else if (w_ev_next) begin
            if (r_sel_ch == SEL_LAST) begin
                r_sel_ch <= '0;
            end else begin
                r_sel_ch <= r_sel_ch + SEL_W'(1);
            end
        end
    end

    // Per-channel next state: free-running blink, then selected-channel rate/mode edits
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_rate_nxt[i] = r_rate[i];
            w_mode_nxt[i] = r_mode[i];
            w_cnt_nxt[i]  = r_cnt[i];
            w_led_nxt[i]  = r_led[i];
            w_hit[i]      = (r_sel_ch == SEL_W'(i));
            w_term[i]     = CNT_W'((CLK_FREQ_HZ >> r_rate[i]) - 32'd1);

            if (r_mode[i] == MODE_BLINK) begin
                if (r_cnt[i] == w_term[i]) begin
                    w_cnt_nxt[i] = '0;
                    w_led_nxt[i] = ~r_led[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else begin
                w_cnt_nxt[i] = '0;
            end

            // A successful rate step restarts the half-period but keeps the current LED level
            if (w_hit[i]) begin
                if (w_ev_up && (r_rate[i] != RATE_MAX)) begin
                    w_rate_nxt[i] = r_rate[i] + RATE_W'(1);
                    w_cnt_nxt[i]  = '0;
                    w_led_nxt[i]  = r_led[i];
                end else if (w_ev_dn && (r_rate[i] != '0)) begin
                    w_rate_nxt[i] = r_rate[i] - RATE_W'(1);
                    w_cnt_nxt[i]  = '0;
                    w_led_nxt[i]  = r_led[i];
                end else if (w_ev_mode) begin
                    w_cnt_nxt[i] = '0;
                    case (r_mode[i])
                        MODE_BLINK: begin
                            w_mode_nxt[i] = MODE_ON;
                            w_led_nxt[i]  = 1'b1;
                        end
                        MODE_ON: begin
                            w_mode_nxt[i] = MODE_OFF;
                            w_led_nxt[i]  = 1'b0;
                        end
                        default: begin
                            w_mode_nxt[i] = MODE_BLINK;
                            w_led_nxt[i]  = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_rate[i] <= RATE_RST;
                r_mode[i] <= MODE_BLINK;
                r_cnt[i]  <= '0;
            end
            r_led <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_rate[i] <= w_rate_nxt[i];
                r_mode[i] <= w_mode_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
            end
            r_led <= w_led_nxt;
        end
    end

    // Outputs: LEDs and selection are registered; rate/mode are muxes of the selected channel
    assign led      = r_led;
    assign sel_ch   = r_sel_ch;
    assign sel_rate = r_rate[r_sel_ch];
    assign sel_mode = r_mode[r_sel_ch];

endmodule

// File: tb/tb_multi_channel_blinker.sv
// Self-checking bench for multi_channel_blinker: directed scenarios followed by random
// button traffic, compared every cycle against a timestamp-based behavioural model.
module tb_multi_channel_blinker;

    localparam int CLK_HZ = 64;
    localparam int NCH    = 4;
    localparam int NRATE  = 5;
    localparam int DEFR   = 1;
    localparam int DEB    = 4;
    // raw edge -> pulse is 2 sync + DEB debounce cycles; registers update one cycle later
    localparam int EFFECT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button = 4'b0;
    logic [3:0] led;
    logic [1:0] sel_ch;
    logic [2:0] sel_rate;
    logic [1:0] sel_mode;

    multi_channel_blinker #(
        .CLK_FREQ_HZ (CLK_HZ),
        .N_CH        (NCH),
        .NUM_RATES   (NRATE),
        .DEFAULT_RATE(DEFR),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .button  (button),
        .led     (led),
        .sel_ch  (sel_ch),
        .sel_rate(sel_rate),
        .sel_mode(sel_mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hold_left = 0;

    // Model: per channel mode (0 blink,1 on,2 off), rate, blink start edge and level at start
    int m_rate [NCH];
    int m_mode [NCH];
    int m_s    [NCH];
    int m_b    [NCH];
    int m_sel;
    int ev_cyc [4] = '{-1, -1, -1, -1};

    function automatic int hp(input int r);
        return CLK_HZ >> r;
    endfunction

    function automatic logic model_led(input int ch, input int n);
        if (m_mode[ch] == 1) return 1'b1;
        if (m_mode[ch] == 2) return 1'b0;
        return 1'(m_b[ch] ^ (((n - m_s[ch]) / hp(m_rate[ch])) % 2));
    endfunction

    task automatic model_reset(input int n);
        for (int ch = 0; ch < NCH; ch++) begin
            m_rate[ch] = DEFR;
            m_mode[ch] = 0;
            m_s[ch]    = n;
            m_b[ch]    = 0;
        end
        m_sel = 0;
        for (int b = 0; b < 4; b++) ev_cyc[b] = -1;
    endtask

    task automatic model_event(input int n);
        int win;
        int ch;
        int old;
        win = -1;
        for (int b = 3; b >= 0; b--) begin
            if (ev_cyc[b] == n) begin
                win = b;
                ev_cyc[b] = -1;
            end
        end
        ch = m_sel;
        old = int'(model_led(ch, n - 1));
        case (win)
            0: if (m_rate[ch] < NRATE - 1) begin
                m_rate[ch]++;
                m_s[ch] = n;
                m_b[ch] = old;
            end
            1: if (m_rate[ch] > 0) begin
                m_rate[ch]--;
                m_s[ch] = n;
                m_b[ch] = old;
            end
            2: m_sel = (m_sel + 1) % NCH;
            3: begin
                if (m_mode[ch] == 0) m_mode[ch] = 1;
                else if (m_mode[ch] == 1) m_mode[ch] = 2;
                else begin
                    m_mode[ch] = 0;
                    m_s[ch] = n;
                    m_b[ch] = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_led;
        for (int ch = 0; ch < NCH; ch++) exp_led[ch] = model_led(ch, cyc);
        chk("led", 32'(led), 32'(exp_led));
        chk("sel_ch", 32'(sel_ch), 32'(m_sel));
        chk("sel_rate", 32'(sel_rate), 32'(m_rate[m_sel]));
        chk("sel_mode", 32'(sel_mode), 32'(m_mode[m_sel]));
    endtask

    // One clock edge: advance model, check outputs 1 time unit later, release held buttons
    task automatic tick();
        logic rst_now;
        rst_now = rst_n;
        @(posedge clk);
        cyc++;
        if (!rst_now) model_reset(cyc);
        else model_event(cyc);
        #1;
        check_model();
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) button = 4'b0;
        end
    endtask

    task automatic start_press(input logic [3:0] mask, input int len);
        button    = mask;
        hold_left = len;
        if (len >= DEB) begin
            for (int b = 0; b < 4; b++) if (mask[b]) ev_cyc[b] = cyc + EFFECT;
        end
    endtask

    task automatic press(input logic [3:0] mask, input int len, input int gap);
        start_press(mask, len);
        repeat (len + gap) tick();
    endtask

    initial begin
        // 1: reset, then free-running blink at the default rate
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_sel_ch", 32'(sel_ch), 32'h0);
        chk("rst_sel_rate", 32'(sel_rate), 32'h1);
        chk("rst_sel_mode", 32'(sel_mode), 32'h0);
        rst_n = 1'b1;
        repeat (31) tick();
        chk("first_rise_pre", 32'(led), 32'h0);
        tick();
        chk("first_rise", 32'(led), 32'hF);
        repeat (168) tick();

        // 2: rate up latency, saturation at both ends
        start_press(4'b0001, 10);
        repeat (EFFECT - 1) tick();
        chk("rate_latency_pre", 32'(sel_rate), 32'h1);
        tick();
        chk("rate_latency", 32'(sel_rate), 32'h2);
        repeat (23) tick();
        repeat (4) press(4'b0001, 10, 20);
        chk("rate_sat_hi", 32'(sel_rate), 32'h4);
        repeat (6) press(4'b0010, 10, 70);
        chk("rate_sat_lo", 32'(sel_rate), 32'h0);

        // 3: short glitch ignored, then channel select wraps
        press(4'b0100, DEB - 1, 20);
        chk("glitch_sel", 32'(sel_ch), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            press(4'b0100, 10, 20);
            chk("sel_wrap", 32'(sel_ch), 32'(k % NCH));
        end

        // 4: mode cycle on channel 2
        press(4'b0100, 10, 20);
        press(4'b0100, 10, 20);
        start_press(4'b1000, 10);
        repeat (EFFECT) tick();
        chk("mode_on", 32'(sel_mode), 32'h1);
        chk("led2_on", 32'(led[2]), 32'h1);
        repeat (23) tick();
        start_press(4'b1000, 10);
        repeat (EFFECT) tick();
        chk("mode_off", 32'(sel_mode), 32'h2);
        chk("led2_off", 32'(led[2]), 32'h0);
        repeat (23) tick();
        start_press(4'b1000, 10);
        repeat (EFFECT) tick();
        chk("mode_blink", 32'(sel_mode), 32'h0);
        repeat (31) tick();
        chk("blink_rise_pre", 32'(led[2]), 32'h0);
        tick();
        chk("blink_rise", 32'(led[2]), 32'h1);
        repeat (20) tick();

        // 5: simultaneous presses, only rate up acts
        press(4'b0100, 10, 20);
        press(4'b0100, 10, 20);
        press(4'b0101, 10, 20);
        chk("prio_sel", 32'(sel_ch), 32'h0);
        chk("prio_rate", 32'(sel_rate), 32'h1);

        // 6: reset mid-operation with ch1 at rate 3, mode ON
        press(4'b0100, 10, 20);
        press(4'b0001, 10, 20);
        press(4'b0001, 10, 20);
        press(4'b1000, 10, 20);
        chk("pre_rst_rate", 32'(sel_rate), 32'h3);
        chk("pre_rst_mode", 32'(sel_mode), 32'h1);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_sel", 32'(sel_ch), 32'h0);
        chk("mid_rst_rate", 32'(sel_rate), 32'h1);
        chk("mid_rst_mode", 32'(sel_mode), 32'h0);
        repeat (5) tick();

        // Random button traffic with occasional resets
        for (int it = 0; it < 60; it++) begin
            int r;
            int len;
            logic [3:0] mask;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                repeat (5) tick();
            end else begin
                if (r < 9) mask = 4'(1 << $urandom_range(0, 3));
                else mask = 4'($urandom_range(1, 15));
                len = $urandom_range(1, 12);
                press(mask, len, $urandom_range(12, 40));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
